// File: rtl/dmem_wbuf_bridge_pkg.sv
// Shared types for the data-memory write-buffer bridge.
// Entry address is stored zero-extended to AW_MAX bits.
package dmem_pkg;

   localparam int AW_MAX = 64;
   localparam logic [3:0] WSTRB_READ = 4'b0000;

   typedef struct packed {
      logic [AW_MAX-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        strb;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      WR_ISSUE,
      RD_ISSUE,
      RD_WAIT
   } dmem_state_t;

   // Narrow stores arrive right-aligned; copy them into every lane.
   function automatic logic [31:0] lane_replicate(
      input logic [3:0]  dwe,
      input logic [31:0] dwdata
   );
      case ($countones(dwe))
         1:       return {4{dwdata[7:0]}};
         2:       return {2{dwdata[15:0]}};
         default: return dwdata;
      endcase
   endfunction

endpackage

// File: rtl/dmem_wbuf_bridge_if.sv
// Multi-cycle data memory bus: request handshake plus read return.
interface dmem_wbuf_bridge_if #(
   parameter int ADDR_W = 32
);

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/dmem_wbuf_bridge_fifo.sv
// Posted-store FIFO; entries exposed only with DMEM_STORE_FWD_EN.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int WB_DEPTH = 4
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  wb_entry_t                 din,
   input  logic                      pop,
   output wb_entry_t                 head,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(WB_DEPTH):0] count
`ifdef DMEM_STORE_FWD_EN
   ,
   output wb_entry_t                 entries [WB_DEPTH],
   output logic [$clog2(WB_DEPTH)-1:0] rd_idx
`endif
);

   localparam int IW = $clog2(WB_DEPTH);

   wb_entry_t mem [WB_DEPTH];
   logic [IW:0] wr_ptr;
   logic [IW:0] rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[IW-1:0]] <= din;
   end

   // Extra pointer MSB distinguishes full from empty.
   assign head  = mem[rd_ptr[IW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IW] != rd_ptr[IW]) &&
                  (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

`ifdef DMEM_STORE_FWD_EN
   assign entries = mem;
   assign rd_idx  = rd_ptr[IW-1:0];
`endif

endmodule

// File: rtl/dmem_wbuf_bridge.sv
// CPU data port to multi-cycle bus bridge with posted stores.
// DMEM_STORE_FWD_EN adds full-word store-to-load forwarding.
module dmem_wbuf_bridge
   import dmem_pkg::*;
#(
   parameter int WB_DEPTH = 4,
   parameter int ADDR_W   = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [31:0]       dwdata,
   input  logic [3:0]        dwe,
   input  logic              cpu_rd,
   output logic [31:0]       drdata,
   output logic              stall,
   output logic              wb_empty,
   dmem_wbuf_bridge_if.master mem
);

   localparam int IW = $clog2(WB_DEPTH);
   localparam int CW = IW + 1;

   dmem_state_t state, state_n;

   logic rd_done;
   logic store_req;
   logic load_req;
   logic push;
   logic pop;
   logic full;
   logic empty;
   logic fwd_hit;
   logic [CW-1:0] count;
   wb_entry_t push_e;
   wb_entry_t head;
   logic [ADDR_W-1:0] word_addr;
   logic [4:0] shamt;
   logic unused_addr_hi;

   assign store_req = |dwe;
   assign push      = store_req && !full;
   assign load_req  = cpu_rd && !store_req && !rd_done;
   assign word_addr = {daddr[ADDR_W-1:2], 2'b00};
   assign shamt     = {daddr[1:0], 3'b000};

   always_comb begin
      push_e = '0;
      push_e.addr[ADDR_W-1:0] = word_addr;
      push_e.data = lane_replicate(dwe, dwdata);
      push_e.strb = dwe;
   end

`ifdef DMEM_STORE_FWD_EN
   wb_entry_t entries [WB_DEPTH];
   logic [IW-1:0] rd_idx;
   logic [IW-1:0] slot;
   logic fwd_found;
   wb_entry_t fwd_e;
`endif

   wbuf_fifo #(
      .WB_DEPTH (WB_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .din     (push_e),
      .pop     (pop),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
`ifdef DMEM_STORE_FWD_EN
      ,
      .entries (entries),
      .rd_idx  (rd_idx)
`endif
   );

`ifdef DMEM_STORE_FWD_EN
   // Oldest to youngest scan; the last match is the youngest.
   always_comb begin
      fwd_found = 1'b0;
      fwd_e     = '0;
      slot      = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         slot = rd_idx + IW'(i);
         if (CW'(i) < count &&
             entries[slot].addr[ADDR_W-1:0] == word_addr) begin
            fwd_found = 1'b1;
            fwd_e     = entries[slot];
         end
      end
   end

   assign fwd_hit = load_req && fwd_found &&
                    (fwd_e.strb == 4'hF) &&
                    (state == IDLE || state == WR_ISSUE);
`else
   assign fwd_hit = 1'b0;
`endif

   assign stall    = !reset && ((store_req && full) || load_req);
   assign wb_empty = empty;
   assign unused_addr_hi = ^head.addr;

   always_comb begin
      state_n       = state;
      pop           = 1'b0;
      mem.mem_valid = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      mem.mem_wstrb = WSTRB_READ;
      unique case (state)
         IDLE: begin
            if (!empty || push)
               state_n = WR_ISSUE;
            else if (load_req && !fwd_hit)
               state_n = RD_ISSUE;
         end
         WR_ISSUE: begin
            mem.mem_valid = 1'b1;
            mem.mem_addr  = head.addr[ADDR_W-1:0];
            mem.mem_wdata = head.data;
            mem.mem_wstrb = head.strb;
            if (mem.mem_ready) begin
               pop = 1'b1;
               if (count > CW'(1) || push)
                  state_n = WR_ISSUE;
               else if (load_req && !fwd_hit)
                  state_n = RD_ISSUE;
               else
                  state_n = IDLE;
            end
         end
         RD_ISSUE: begin
            mem.mem_valid = 1'b1;
            mem.mem_addr  = word_addr;
            if (mem.mem_ready) state_n = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem.mem_rvalid) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         drdata  <= '0;
         rd_done <= 1'b0;
      end else begin
         state   <= state_n;
         rd_done <= 1'b0;
         if (state == RD_WAIT && mem.mem_rvalid) begin
            drdata  <= mem.mem_rdata >> shamt;
            rd_done <= 1'b1;
         end
`ifdef DMEM_STORE_FWD_EN
         else if (fwd_hit) begin
            drdata  <= fwd_e.data >> shamt;
            rd_done <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dmem_wbuf_bridge.sv
// Randomized bench for dmem_wbuf_bridge against a program-order memory model.
module tb_dmem_wbuf_bridge;

   localparam int WB_DEPTH = 4;
   localparam int ADDR_W   = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic        cpu_rd;
   logic [31:0] drdata;
   logic        stall;
   logic        wb_empty;

   dmem_wbuf_bridge_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_wbuf_bridge #(
      .WB_DEPTH (WB_DEPTH),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .daddr    (daddr),
      .dwdata   (dwdata),
      .dwe      (dwe),
      .cpu_rd   (cpu_rd),
      .drdata   (drdata),
      .stall    (stall),
      .wb_empty (wb_empty),
      .mem      (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } op_t;

   wr_t         exp_wr [$];
   op_t         ops [$];
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] slv_mem [int unsigned];
   logic [31:0] ld_word_exp = '0;
   int          last_stall = 0;
   int          sl_mode = 0;
   bit          rv_block = 1'b0;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
   endfunction

   function automatic logic [31:0] slv_rd(input logic [31:0] a);
      return slv_mem.exists(a >> 2) ? slv_mem[a >> 2] : 32'h0;
   endfunction

   function automatic logic [31:0] lanes(input logic [3:0] be,
                                         input logic [31:0] d);
      int n = $countones(be);
      if (n == 1) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (n == 2) return {d[15:0], d[15:0]};
      return d;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic model_store(input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [3:0] be);
      wr_t w;
      w.addr = {a[31:2], 2'b00};
      w.data = lanes(be, d);
      w.strb = be;
      exp_wr.push_back(w);
      ref_mem[w.addr >> 2] = merge(ref_rd(w.addr), w.data, be);
   endtask

   // Memory-side responder and bus-order checker.
   initial begin : slave
      int          rd_cnt = -1;
      logic [31:0] rd_data = '0;
      bit          prev_v = 1'b0;
      logic [63:0] prev_aw = '0;
      logic [3:0]  prev_s = '0;
      wr_t         w;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (reset) rd_cnt = -1;
         case (sl_mode)
            0:       bus.mem_ready = 1'b1;
            1:       bus.mem_ready = ($urandom_range(0, 1) == 1);
            default: bus.mem_ready = 1'b0;
         endcase
         if (!rv_block) begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (rd_cnt > 0) begin
               rd_cnt--;
               if (rd_cnt == 0) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = rd_data;
                  rd_cnt = -1;
               end
            end else if (sl_mode == 1 &&
                         $urandom_range(0, 7) == 0) begin
               bus.mem_rvalid = 1'b1;
            end
         end
         #2;
         if (reset) begin
            prev_v = 1'b0;
            continue;
         end
         if (prev_v) begin
            chk("hold_aw", {bus.mem_addr, bus.mem_wdata}, prev_aw);
            chk("hold_vs", {bus.mem_valid, bus.mem_wstrb},
                {1'b1, prev_s});
         end
         prev_v  = bus.mem_valid && !bus.mem_ready;
         prev_aw = {bus.mem_addr, bus.mem_wdata};
         prev_s  = bus.mem_wstrb;
         if (bus.mem_valid && bus.mem_ready) begin
            if (bus.mem_wstrb != 4'h0) begin
               chk("wr_expected", 64'(exp_wr.size() > 0), 1);
               if (exp_wr.size() > 0) begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", bus.mem_addr, w.addr);
                  chk("wr_data", bus.mem_wdata, w.data);
                  chk("wr_strb", bus.mem_wstrb, w.strb);
                  slv_mem[bus.mem_addr >> 2] =
                     merge(slv_rd(bus.mem_addr), bus.mem_wdata,
                           bus.mem_wstrb);
               end
            end else begin
               chk("rd_after_drain", exp_wr.size(), 0);
               chk("rd_addr", bus.mem_addr, ld_word_exp);
               rd_data = slv_rd(bus.mem_addr);
               rd_cnt  = (sl_mode == 1) ? $urandom_range(1, 3) : 1;
            end
         end
      end
   end

   task automatic drive_nop();
      dwe    = 4'h0;
      cpu_rd = 1'b0;
      daddr  = $urandom;
      dwdata = $urandom;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      drive_nop();
      #2;
   endtask

   task automatic run_ops(input int budget);
      op_t op;
      bit  busy = 1'b0;
      int  st = 0;
      int  cyc = 0;
      while ((busy || ops.size() > 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (!busy) begin
            op   = ops.pop_front();
            busy = 1'b1;
            st   = 0;
         end
         case (op.kind)
            1: begin
               daddr  = op.addr;
               dwdata = op.data;
               dwe    = op.be;
               cpu_rd = ($urandom_range(0, 3) == 0);
            end
            2: begin
               daddr       = op.addr;
               dwdata      = $urandom;
               dwe         = 4'h0;
               cpu_rd      = 1'b1;
               ld_word_exp = {op.addr[31:2], 2'b00};
            end
            default: drive_nop();
         endcase
         #2;
         case (op.kind)
            1: begin
               if (!stall) begin
                  model_store(op.addr, op.data, op.be);
                  last_stall = st;
                  busy = 1'b0;
               end else st++;
            end
            2: begin
               if (!stall) begin
                  chk("ld_data", drdata,
                      ref_rd(op.addr) >> (8 * op.addr[1:0]));
                  last_stall = st;
                  busy = 1'b0;
               end else st++;
            end
            default: busy = 1'b0;
         endcase
      end
      chk("ops_timeout", 64'(ops.size()) + 64'(busy), 0);
      ops.delete();
   endtask

   task automatic wait_drain(input int budget);
      int cyc = 0;
      do begin
         idle_cycle();
         cyc++;
      end while (!(wb_empty && exp_wr.size() == 0) && cyc < budget);
      chk("drain", 64'(wb_empty && exp_wr.size() == 0), 1);
   endtask

   initial begin : main
      logic [3:0] be_tab [9] = '{4'h1, 4'h2, 4'h4, 4'h8,
                                 4'h3, 4'hC, 4'hF, 4'h5, 4'h6};
      op_t op;
      int  r;
      reset = 1'b1;
      drive_nop();
      repeat (2) @(negedge clk);
      #2;
      chk("rst_stall", stall, 0);
      chk("rst_drdata", drdata, 0);
      chk("rst_valid", bus.mem_valid, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_wstrb", bus.mem_wstrb, 0);
      chk("rst_wb_empty", wb_empty, 1);
      @(negedge clk);
      reset = 1'b0;

      // Word store, then the next-cycle bus request.
      sl_mode = 0;
      ops.push_back('{1, 32'h100, 32'hDEADBEEF, 4'hF});
      run_ops(20);
      chk("sw_nostall", last_stall, 0);
      idle_cycle();
      chk("sw_valid", bus.mem_valid, 1);
      chk("sw_addr", bus.mem_addr, 32'h100);
      chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("sw_wstrb", bus.mem_wstrb, 4'hF);
      wait_drain(50);

      // Byte store at the top lane.
      ops.push_back('{1, 32'h103, 32'h0000005A, 4'h8});
      run_ops(20);
      idle_cycle();
      chk("sb_addr", bus.mem_addr, 32'h100);
      chk("sb_wdata", bus.mem_wdata, 32'h5A5A5A5A);
      chk("sb_wstrb", bus.mem_wstrb, 4'h8);
      wait_drain(50);

      // Fill with the bus stalled; the fifth store waits.
      sl_mode = 2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         daddr  = 32'h140 + 32'(4 * i);
         dwdata = $urandom;
         dwe    = 4'hF;
         cpu_rd = 1'b0;
         #2;
         chk($sformatf("fill%0d_stall", i), stall, i == 4);
         if (!stall) model_store(daddr, dwdata, dwe);
      end
      chk("full_not_empty", wb_empty, 0);
      sl_mode = 0;
      @(negedge clk);
      #2;
      chk("pop_no_bypass", stall, 1);
      @(negedge clk);
      #2;
      chk("fifth_accept", stall, 0);
      if (!stall) model_store(daddr, dwdata, dwe);
      wait_drain(50);

      // Two posted stores, then a load behind them.
      slv_mem[32'h200 >> 2] = 32'h11223344;
      ref_mem[32'h200 >> 2] = 32'h11223344;
      ops.push_back('{1, 32'h180, 32'hA5A5F00D, 4'hF});
      ops.push_back('{1, 32'h185, 32'h000000C3, 4'h2});
      ops.push_back('{2, 32'h200, 32'h0, 4'h0});
      run_ops(50);
      chk("lw_data", drdata, 32'h11223344);

      // Halfword load from the upper half, minimum latency.
      slv_mem[32'h200 >> 2] = 32'hAABBCCDD;
      ref_mem[32'h200 >> 2] = 32'hAABBCCDD;
      ops.push_back('{2, 32'h202, 32'h0, 4'h0});
      run_ops(50);
      chk("lh_data", drdata, 32'h0000AABB);
      chk("ld_latency", last_stall, 3);

      // Reset drops buffered stores.
      sl_mode = 2;
      @(negedge clk);
      daddr  = 32'h240;
      dwdata = 32'h12345678;
      dwe    = 4'hF;
      cpu_rd = 1'b0;
      #2;
      chk("drop_push", stall, 0);
      idle_cycle();
      chk("drop_buffered", wb_empty, 0);
      reset = 1'b1;
      #1;
      chk("drop_wb_empty", wb_empty, 1);
      chk("drop_valid", bus.mem_valid, 0);
      @(negedge clk);
      reset   = 1'b0;
      sl_mode = 0;

      // Reset while waiting for read data.
      rv_block       = 1'b1;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      daddr       = 32'h200;
      dwe         = 4'h0;
      cpu_rd      = 1'b1;
      ld_word_exp = 32'h200;
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("rw_stall", stall, 1);
      reset = 1'b1;
      #1;
      chk("rw_rst_valid", bus.mem_valid, 0);
      chk("rw_rst_stall", stall, 0);
      chk("rw_rst_drdata", drdata, 0);
      @(negedge clk);
      drive_nop();
      reset = 1'b0;
      @(negedge clk);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hCAFEF00D;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #2;
      chk("late_rvalid_drdata", drdata, 0);
      chk("late_rvalid_stall", stall, 0);
      rv_block = 1'b0;

      // Randomized mix against the program-order model.
      sl_mode = 1;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         op.addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
         op.data = $urandom;
         op.be   = 4'h0;
         if (r < 4) begin
            op.kind = 1;
            op.be   = be_tab[$urandom_range(0, 8)];
            op.addr[1:0] = 2'($urandom_range(0, 3));
         end else if (r < 7) begin
            op.kind = 2;
            case ($urandom_range(0, 2))
               0: op.addr[1:0] = 2'($urandom_range(0, 3));
               1: op.addr[1:0] = {1'($urandom_range(0, 1)), 1'b0};
               default: op.addr[1:0] = 2'b00;
            endcase
         end else begin
            op.kind = 0;
         end
         ops.push_back(op);
      end
      run_ops(20000);
      idle_cycle();
      sl_mode = 0;
      wait_drain(100);
      chk("final_wb_empty", wb_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
